mem_image_loader: RTL

MEM_IMAGE_LOADER -- requirements
Module: mem_image_loader

---
 rtl/mem_image_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_image_loader.sv
// Copies a DEPTH-word image from a combinational source into RAM at BASE_ADDR and can then
// read the RAM back and compare it against the image, holding the downstream CPU in reset.
module mem_image_loader #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned BASE_ADDR  = 0,
    parameter bit          AUTO_START = 1'b1,
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              verify_en,
    output logic [IDX_W-1:0]  img_idx,
    input  logic [DATA_W-1:0] img_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  err_idx,
    output logic              hold_n
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StVerify, StVflush, StFin} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                verify_q, verify_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic [IDX_W-1:0]    cmp_idx_q, cmp_idx_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [IDX_W-1:0]    err_idx_q, err_idx_d;
    // High for the first cycle after reset release; keeps hold_n low until the loader decides.
    logic                auto_pend_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            verify_q    <= 1'b0;
            exp_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_idx_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_idx_q   <= '0;
            auto_pend_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            verify_q    <= verify_d;
            exp_q       <= exp_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_idx_q   <= cmp_idx_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_idx_q   <= err_idx_d;
            auto_pend_q <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        verify_d  = verify_q;
        exp_d     = exp_q;
        cmp_vld_d = 1'b0;
        cmp_idx_d = cmp_idx_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        ram_wren  = 1'b0;
        ram_wdata = '0;
        img_idx   = idx_q;
        ram_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);

        // Readback compare lags the address by one cycle; only the first mismatch is recorded.
        if (cmp_vld_q && (ram_rdata != exp_q)) begin
            error_d = 1'b1;
            if (!error_q) begin
                err_idx_d = cmp_idx_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start || (AUTO_START && auto_pend_q)) begin
                    idx_d     = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    verify_d  = verify_en;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                ram_wren  = 1'b1;
                ram_wdata = img_data;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = verify_q ? StVerify : StFin;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StVerify: begin
                exp_d     = img_data;
                cmp_vld_d = 1'b1;
                cmp_idx_d = idx_q;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StVflush;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StVflush: begin
                state_d = StFin;
            end
            StFin: begin
                done_d  = ~error_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign hold_n  = ~busy & ~auto_pend_q;
    assign done    = done_q;
    assign error   = error_q;
    assign err_idx = err_idx_q;

endmodule
